mdu_mult_ctrl: RTL and testbench
================================

Name: mdu_mult_ctrl

Overview:
Sequencing controller for the pipelined signed/unsigned 32x32 booth/Wallace multiplier in the EX stage. It accepts one multiply-class instruction at a time from EX, drives the multiplier operands, and waits out the multiplier's register latency. It then writes the architectural HI/LO pair, which it owns, or returns the low word for MUL. It also performs the extra accumulate cycle for MADD/MSUB and cancels in-flight work on pipeline flush.

Parameters:
MUL_LAT, 1, cycles from operands presented on mul_scr0/mul_scr1 to mul_res valid; legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  EX presents an operation
req_ready  out  1  controller can accept; high exactly when state is IDLE
req_op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MUL, 7 reserved
req_a  in  32  rs operand
req_b  in  32  rt operand
flush  in  1  exception/branch flush; kills the accepted op
mt_hi_we  in  1  MTHI write enable
mt_lo_we  in  1  MTLO write enable
mt_wdata  in  32  MTHI/MTLO data
mul_scr0  out  32  multiplier operand 0 (registered)
mul_scr1  out  32  multiplier operand 1 (registered)
mul_multop  out  1  multiplier signedness: 1 signed, 0 unsigned (registered)
mul_res  in  64  multiplier product
hi  out  32  architectural HI register
lo  out  32  architectural LO register
resp_valid  out  1  one-cycle completion pulse (registered)
resp_lo  out  32  product[31:0] for MUL; 0 for other ops (registered)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; hi, lo, mul_scr0, mul_scr1, resp_lo = 0; mul_multop, resp_valid = 0; wait counter = 0.
- Handshake: an op is accepted on a rising edge where req_valid & req_ready & !flush. Reserved op 7 is consumed and dropped: no state change, no resp.
- On accept: latch req_a/req_b into mul_scr0/mul_scr1; mul_multop = 1 for ops 0, 2, 4, 6; latch op; go ISSUE.
- ISSUE (1 cycle): operands stable at the multiplier; load counter = MUL_LAT-1; go WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter reads 0, mul_res is valid:
  - MULT/MULTU: {hi,lo} <= mul_res at that edge; go IDLE.
  - MUL: resp_lo <= mul_res[31:0] at that edge; HI/LO unchanged; go IDLE.
  - MADD*/MSUB*: capture mul_res into a 64-bit prod register; go ACC.
- ACC (1 cycle): {hi,lo} <= {hi,lo} + prod (MADD/MADDU) or {hi,lo} - prod (MSUB/MSUBU), modulo 2^64; go IDLE.
- resp_valid pulses high for the single cycle right after the completing edge, so new hi/lo/resp_lo are visible in that same cycle.
- Latency with MUL_LAT=1, accept edge ending cycle 0: ISSUE cycle 1, WAIT cycle 2, result visible with resp_valid in cycle 3. Accumulate ops complete in cycle 4. General: 2+MUL_LAT, plus 1 for accumulate.
- Back-to-back: req_ready rises in the resp_valid cycle, so the next accept happens at the end of that cycle.
- mul_scr*/mul_multop hold their values until the next accept; they are never cleared except by reset.
- flush in any non-IDLE state: next edge goes to IDLE with no HI/LO write, no resp_valid, and resp_lo unchanged. Flush on the completing edge wins over the write. Flush in IDLE blocks acceptance.
- MTHI/MTLO: applied at any edge. If an MT write and a controller HI/LO write hit the same edge, the controller write wins for both halves. ACC uses hi/lo as registered at its cycle, including any earlier MT write. Pipeline hazard logic stalls MT writes while busy; the controller does not check this.
- Reset asserted mid-operation: immediate return to reset values; the in-flight op is lost.

Decomposition:
- Shared package mdu_pkg holds: op encodings (OP_MULT..OP_MUL), state enum (IDLE, ISSUE, WAIT, ACC), default MUL_LAT.
- One sub-module, mdu_hilo_acc: combinational 64-bit add/sub of {hi,lo} and prod, selected by a sub flag.
- The multiplier is instantiated by the parent; this block only drives and samples it.

Test Plan:
- Reset, then MULT a=0xFFFFFFFF, b=0x00000002 -> cycle 3: resp_valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE; req_ready=1.
- MULTU a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; mul_multop=0 during ISSUE/WAIT.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 -> cycle 4: hi=0x00000001, lo=0x00000000. Then MSUB a=3, b=5 from hi=lo=0 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MUL a=0x00010001, b=0x00010001 with hi=0x12345678, lo=0x9ABCDEF0 -> resp_lo=0x00020001; hi/lo unchanged.
- MADD accepted, flush asserted in WAIT -> no resp_valid, hi/lo unchanged, req_ready=1 next cycle. Repeat with flush in ACC -> same.
- MUL_LAT=3 build, MULT 7x6 back-to-back with MULTU 2x3 -> lo=42 at cycle 5, lo=6 at cycle 10. rst pulsed during second op's WAIT -> all outputs 0, req_ready=1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, controller
// states and the default multiplier latency.
package mdu_pkg;

    localparam int MUL_LAT_DEFAULT = 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5,
        OP_MUL   = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACC
    } state_e;

    // Even encodings are the signed flavours of each operation.
    function automatic logic op_is_signed(input logic [2:0] op);
        return !op[0];
    endfunction

    function automatic logic op_is_sub(input op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/mdu_hilo_acc.sv
// Combinational 64-bit accumulate of the HI/LO pair with a product, used by the
// MADD/MSUB family; wraps modulo 2^64.
module mdu_hilo_acc (
    input  logic [63:0] acc_i,
    input  logic [63:0] prod_i,
    input  logic        sub_i,
    output logic [63:0] res_o
);

    assign res_o = sub_i ? (acc_i - prod_i) : (acc_i + prod_i);

endmodule

// File: rtl/mdu_mult_ctrl.sv
// Sequencing controller for the EX-stage multiplier: issues operands, waits out
// the multiplier latency, and owns the architectural HI/LO pair.
module mdu_mult_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic        mt_hi_we,
    input  logic        mt_lo_we,
    input  logic [31:0] mt_wdata,
    output logic [31:0] mul_scr0,
    output logic [31:0] mul_scr1,
    output logic        mul_multop,
    input  logic [63:0] mul_res,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        resp_valid,
    output logic [31:0] resp_lo,
    output logic        busy
);

    localparam logic [1:0] CNT_INIT = 2'(MUL_LAT - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] scr0_q, scr0_d;
    logic [31:0] scr1_q, scr1_d;
    logic        multop_q, multop_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_lo_q, resp_lo_d;
    logic [63:0] acc_res;

    mdu_hilo_acc u_acc (
        .acc_i  ({hi_q, lo_q}),
        .prod_i (prod_q),
        .sub_i  (op_is_sub(op_q)),
        .res_o  (acc_res)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        scr0_d       = scr0_q;
        scr1_d       = scr1_q;
        multop_d     = multop_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        prod_d       = prod_q;
        resp_valid_d = 1'b0;
        resp_lo_d    = resp_lo_q;

        // MT writes land first so a controller write on the same edge overrides them.
        if (mt_hi_we) hi_d = mt_wdata;
        if (mt_lo_we) lo_d = mt_wdata;

        unique case (state_q)
            IDLE: begin
                if (req_valid && !flush && (req_op != OP_RSVD)) begin
                    scr0_d   = req_a;
                    scr1_d   = req_b;
                    multop_d = op_is_signed(req_op);
                    op_d     = op_e'(req_op);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 2'd0) begin
                    unique case (op_q)
                        OP_MULT, OP_MULTU: begin
                            {hi_d, lo_d} = mul_res;
                            resp_lo_d    = 32'd0;
                            resp_valid_d = 1'b1;
                            state_d      = IDLE;
                        end
                        OP_MUL: begin
                            resp_lo_d    = mul_res[31:0];
                            resp_valid_d = 1'b1;
                            state_d      = IDLE;
                        end
                        default: begin
                            prod_d  = mul_res;
                            state_d = ACC;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    {hi_d, lo_d} = acc_res;
                    resp_lo_d    = 32'd0;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_MULT;
            cnt_q        <= 2'd0;
            scr0_q       <= 32'd0;
            scr1_q       <= 32'd0;
            multop_q     <= 1'b0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            prod_q       <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_lo_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            scr0_q       <= scr0_d;
            scr1_q       <= scr1_d;
            multop_q     <= multop_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            prod_q       <= prod_d;
            resp_valid_q <= resp_valid_d;
            resp_lo_q    <= resp_lo_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mul_scr0   = scr0_q;
    assign mul_scr1   = scr1_q;
    assign mul_multop = multop_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign resp_valid = resp_valid_q;
    assign resp_lo    = resp_lo_q;

endmodule

// File: tb/tb_mdu_mult_ctrl.sv
// Bench for mdu_mult_ctrl: a latency-1 instance checked every cycle against a
// transaction-level model, plus a latency-3 instance driven by directed checks.
module tb_mdu_mult_ctrl;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    // Instance A (MUL_LAT = 1)
    logic        rst;
    logic        reqValid, reqReady, flush, mtHiWe, mtLoWe;
    logic [2:0]  reqOp;
    logic [31:0] reqA, reqB, mtWdata;
    logic [31:0] mulScr0, mulScr1, hi, lo, respLo;
    logic        mulMultop, respValid, busy;
    logic [63:0] mulRes;

    // Instance B (MUL_LAT = 3)
    logic        rstB;
    logic        reqValidB, reqReadyB;
    logic [2:0]  reqOpB;
    logic [31:0] reqAB, reqBB;
    logic [31:0] mulScr0B, mulScr1B, hiB, loB, respLoB;
    logic        mulMultopB, respValidB, busyB;
    logic [63:0] mulResB;

    mdu_mult_ctrl #(.MUL_LAT(LAT_A)) dutA (
        .clk(clk), .rst(rst),
        .req_valid(reqValid), .req_ready(reqReady), .req_op(reqOp),
        .req_a(reqA), .req_b(reqB), .flush(flush),
        .mt_hi_we(mtHiWe), .mt_lo_we(mtLoWe), .mt_wdata(mtWdata),
        .mul_scr0(mulScr0), .mul_scr1(mulScr1), .mul_multop(mulMultop),
        .mul_res(mulRes), .hi(hi), .lo(lo),
        .resp_valid(respValid), .resp_lo(respLo), .busy(busy)
    );

    mdu_mult_ctrl #(.MUL_LAT(LAT_B)) dutB (
        .clk(clk), .rst(rstB),
        .req_valid(reqValidB), .req_ready(reqReadyB), .req_op(reqOpB),
        .req_a(reqAB), .req_b(reqBB), .flush(1'b0),
        .mt_hi_we(1'b0), .mt_lo_we(1'b0), .mt_wdata(32'd0),
        .mul_scr0(mulScr0B), .mul_scr1(mulScr1B), .mul_multop(mulMultopB),
        .mul_res(mulResB), .hi(hiB), .lo(loB),
        .resp_valid(respValidB), .resp_lo(respLoB), .busy(busyB)
    );

    // Pipelined multiplier stand-ins: LAT register stages from operands to product.
    function automatic logic [63:0] mulFn(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ae, be;
        ae = s ? {{32{a[31]}}, a} : {32'd0, a};
        be = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ae * be;
    endfunction

    logic [63:0] pipeA [LAT_A];
    logic [63:0] pipeB [LAT_B];

    always @(posedge clk) begin
        pipeA[0] <= mulFn(mulScr0, mulScr1, mulMultop);
        for (int i = 1; i < LAT_A; i++) pipeA[i] <= pipeA[i-1];
        pipeB[0] <= mulFn(mulScr0B, mulScr1B, mulMultopB);
        for (int i = 1; i < LAT_B; i++) pipeB[i] <= pipeB[i-1];
    end

    assign mulRes  = pipeA[LAT_A-1];
    assign mulResB = pipeB[LAT_B-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of instance A: an accepted op completes a fixed
    // number of edges later unless flushed; results follow the ISA arithmetic.
    bit          mBusy, mRespValid;
    int          mRem;
    logic [2:0]  mOp;
    logic [31:0] mA, mB, mHi, mLo, mRespLo;

    initial begin
        logic [31:0] nHi, nLo;
        logic [63:0] p, cur;
        longint      sa, sb;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mBusy = 0; mRespValid = 0; mRem = 0; mOp = 3'd0;
                mA = 0; mB = 0; mHi = 0; mLo = 0; mRespLo = 0;
            end else begin
                nHi = mtHiWe ? mtWdata : mHi;
                nLo = mtLoWe ? mtWdata : mLo;
                mRespValid = 0;
                if (mBusy) begin
                    if (flush) begin
                        mBusy = 0;
                    end else begin
                        mRem--;
                        if (mRem == 0) begin
                            if (mOp[0] == 1'b0) begin
                                sa = longint'($signed(mA));
                                sb = longint'($signed(mB));
                                p  = 64'(sa * sb);
                            end else begin
                                p = {32'd0, mA} * {32'd0, mB};
                            end
                            cur = {mHi, mLo};
                            case (mOp)
                                3'd0, 3'd1: begin {nHi, nLo} = p;       mRespLo = 0;        end
                                3'd2, 3'd3: begin {nHi, nLo} = cur + p; mRespLo = 0;        end
                                3'd4, 3'd5: begin {nHi, nLo} = cur - p; mRespLo = 0;        end
                                default:    begin                       mRespLo = p[31:0];  end
                            endcase
                            mRespValid = 1;
                            mBusy = 0;
                        end
                    end
                end else if (reqValid && !flush && reqOp != 3'd7) begin
                    mBusy = 1;
                    mOp = reqOp;
                    mA = reqA;
                    mB = reqB;
                    mRem = LAT_A + 1 + ((reqOp >= 3'd2 && reqOp <= 3'd5) ? 1 : 0);
                end
                mHi = nHi;
                mLo = nLo;
            end
        end
    end

    // Per-cycle comparison of instance A against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("req_ready", 64'(reqReady), 64'(!mBusy));
                checkOutput("busy", 64'(busy), 64'(mBusy));
                checkOutput("hi", 64'(hi), 64'(mHi));
                checkOutput("lo", 64'(lo), 64'(mLo));
                checkOutput("resp_valid", 64'(respValid), 64'(mRespValid));
                checkOutput("resp_lo", 64'(respLo), 64'(mRespLo));
                if (mBusy) begin
                    checkOutput("mul_scr0", 64'(mulScr0), 64'(mA));
                    checkOutput("mul_scr1", 64'(mulScr1), 64'(mB));
                    checkOutput("mul_multop", 64'(mulMultop), 64'(!mOp[0]));
                end
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        reqValid = 1'b1;
        reqOp    = op;
        reqA     = a;
        reqB     = b;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic mtWrite(input logic toHi, input logic [31:0] data);
        mtHiWe  = toHi;
        mtLoWe  = !toHi;
        mtWdata = data;
        @(posedge clk);
        #1;
        mtHiWe = 1'b0;
        mtLoWe = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; rstB = 1'b1;
        reqValid = 0; reqOp = 0; reqA = 0; reqB = 0; flush = 0;
        mtHiWe = 0; mtLoWe = 0; mtWdata = 0;
        reqValidB = 0; reqOpB = 0; reqAB = 0; reqBB = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rstB = 1'b0;

        checkOutput("rst hi", 64'(hi), 64'd0);
        checkOutput("rst lo", 64'(lo), 64'd0);
        checkOutput("rst resp_valid", 64'(respValid), 64'd0);
        checkOutput("rst req_ready", 64'(reqReady), 64'd1);
        checkOutput("rst mul_scr0", 64'(mulScr0), 64'd0);
        checkOutput("rst mul_multop", 64'(mulMultop), 64'd0);

        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        waitCycles(2);
        checkOutput("MULT resp_valid", 64'(respValid), 64'd1);
        checkOutput("MULT hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("MULT lo", 64'(lo), 64'hFFFF_FFFE);
        checkOutput("MULT req_ready", 64'(reqReady), 64'd1);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        checkOutput("MULTU multop issue", 64'(mulMultop), 64'd0);
        waitCycles(1);
        checkOutput("MULTU multop wait", 64'(mulMultop), 64'd0);
        waitCycles(1);
        checkOutput("MULTU hi", 64'(hi), 64'h0000_0001);
        checkOutput("MULTU lo", 64'(lo), 64'hFFFF_FFFE);

        mtWrite(1'b1, 32'h0000_0000);
        mtWrite(1'b0, 32'hFFFF_FFFF);
        applyStimulus(3'd3, 32'd1, 32'd1);
        waitCycles(2);
        checkOutput("MADDU acc cycle resp_valid", 64'(respValid), 64'd0);
        waitCycles(1);
        checkOutput("MADDU resp_valid", 64'(respValid), 64'd1);
        checkOutput("MADDU hi", 64'(hi), 64'h0000_0001);
        checkOutput("MADDU lo", 64'(lo), 64'h0000_0000);

        mtWrite(1'b1, 32'd0);
        mtWrite(1'b0, 32'd0);
        applyStimulus(3'd4, 32'd3, 32'd5);
        waitCycles(3);
        checkOutput("MSUB hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("MSUB lo", 64'(lo), 64'hFFFF_FFF1);

        mtWrite(1'b1, 32'h1234_5678);
        mtWrite(1'b0, 32'h9ABC_DEF0);
        applyStimulus(3'd6, 32'h0001_0001, 32'h0001_0001);
        waitCycles(2);
        checkOutput("MUL resp_lo", 64'(respLo), 64'h0002_0001);
        checkOutput("MUL hi", 64'(hi), 64'h1234_5678);
        checkOutput("MUL lo", 64'(lo), 64'h9ABC_DEF0);

        applyStimulus(3'd2, 32'd7, 32'd7);
        waitCycles(1);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("flush WAIT resp_valid", 64'(respValid), 64'd0);
        checkOutput("flush WAIT req_ready", 64'(reqReady), 64'd1);
        checkOutput("flush WAIT lo", 64'(lo), 64'h9ABC_DEF0);

        applyStimulus(3'd2, 32'd7, 32'd7);
        waitCycles(2);
        flush = 1'b1;
        waitCycles(1);
        flush = 1'b0;
        checkOutput("flush ACC resp_valid", 64'(respValid), 64'd0);
        checkOutput("flush ACC req_ready", 64'(reqReady), 64'd1);
        checkOutput("flush ACC hi", 64'(hi), 64'h1234_5678);
        checkOutput("flush ACC resp_lo", 64'(respLo), 64'h0002_0001);

        applyStimulus(3'd7, 32'd1, 32'd1);
        checkOutput("RSVD busy", 64'(busy), 64'd0);
        waitCycles(3);
        checkOutput("RSVD resp_valid", 64'(respValid), 64'd0);

        // Latency-3 instance: back-to-back MULT/MULTU, then a reset mid-flight.
        reqValidB = 1'b1; reqOpB = 3'd0; reqAB = 32'd7; reqBB = 32'd6;
        waitCycles(1);
        reqOpB = 3'd1; reqAB = 32'd2; reqBB = 32'd3;
        waitCycles(4);
        checkOutput("B MULT resp_valid", 64'(respValidB), 64'd1);
        checkOutput("B MULT lo", 64'(loB), 64'd42);
        checkOutput("B MULT hi", 64'(hiB), 64'd0);
        checkOutput("B req_ready", 64'(reqReadyB), 64'd1);
        waitCycles(1);
        reqValidB = 1'b0;
        waitCycles(4);
        checkOutput("B MULTU resp_valid", 64'(respValidB), 64'd1);
        checkOutput("B MULTU lo", 64'(loB), 64'd6);
        reqValidB = 1'b1; reqOpB = 3'd0; reqAB = 32'h1234; reqBB = 32'h10;
        waitCycles(1);
        reqValidB = 1'b0;
        waitCycles(1);
        checkOutput("B busy in WAIT", 64'(busyB), 64'd1);
        rstB = 1'b1;
        #2;
        checkOutput("B rst lo", 64'(loB), 64'd0);
        checkOutput("B rst hi", 64'(hiB), 64'd0);
        checkOutput("B rst mul_scr0", 64'(mulScr0B), 64'd0);
        checkOutput("B rst mul_scr1", 64'(mulScr1B), 64'd0);
        checkOutput("B rst req_ready", 64'(reqReadyB), 64'd1);
        checkOutput("B rst resp_lo", 64'(respLoB), 64'd0);
        rstB = 1'b0;
        waitCycles(4);
        checkOutput("B after rst resp_valid", 64'(respValidB), 64'd0);
        checkOutput("B after rst lo", 64'(loB), 64'd0);

        // Randomized traffic on instance A, checked by the model each cycle.
        repeat (3000) begin
            reqValid = ($urandom_range(0, 9) < 6);
            reqOp    = 3'($urandom_range(0, 7));
            reqA     = pickOperand();
            reqB     = pickOperand();
            flush    = ($urandom_range(0, 19) == 0);
            mtHiWe   = ($urandom_range(0, 9) == 0);
            mtLoWe   = ($urandom_range(0, 9) == 0);
            mtWdata  = $urandom;
            waitCycles(1);
        end
        reqValid = 0; flush = 0; mtHiWe = 0; mtLoWe = 0;
        waitCycles(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
